// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults, bit-period derivation and FSM state encoding
package uart_pkg;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_UART_BPS = 2_500_000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // A one-clock bit period still needs a one-bit counter.
  function automatic int calc_cnt_width(input int bps_cnt);
    return (bps_cnt > 1) ? $clog2(bps_cnt) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with clear input and end-of-bit tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BPS_CNT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = calc_cnt_width(BPS_CNT);
  localparam logic [CW-1:0]   LAST = CW'(BPS_CNT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while cleared so every state entry starts a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst_n || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_send.sv
// rtl/uart_send.sv - 8N1 UART transmitter with registered serial output
module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int UART_BPS = DEF_UART_BPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_txd,
  output logic       uart_tx_busy,
  output logic       uart_tx_done
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

  logic [1:0] state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       bit_tick;
  logic       baud_clr;

  assign baud_clr = (state == ST_IDLE);

  uart_baud_gen #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
      uart_tx_done <= 1'b0;
    end else begin
      uart_tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The start bit goes out from the register loaded on the accepting edge.
          if (uart_en) begin
            shift_reg    <= uart_din;
            bit_cnt      <= '0;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
            state        <= ST_START;
          end else begin
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            bit_cnt  <= '0;
            uart_txd <= shift_reg[0];
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= ST_STOP;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_txd <= shift_reg[bit_cnt + 3'd1];
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            uart_tx_done <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// tb/tb_uart_send.sv - self-checking bench for uart_send against a frame-timing model
module tb_uart_send;

  localparam int BPS   = 100_000_000 / 2_500_000;
  localparam int FRAME = 10 * BPS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       uart_en = 1'b0;
  logic [7:0] uart_din = 8'h00;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic       uart_tx_done;

  uart_send dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_done (uart_tx_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: a frame is described only by the elapsed clocks since acceptance.
  bit         m_active = 1'b0;
  int         m_el = 0;
  logic [7:0] m_data = 8'h00;
  logic       exp_txd = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  int         exp_done_cnt = 0;
  int         dut_done_cnt = 0;
  logic [7:0] sent_q[$];

  // Line decoder sampling mid-bit, used as the loopback receiver.
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [9:0] fv;
    bit idle;
    idle = !m_active || (m_el >= FRAME + 1);
    if (rst_n) begin
      m_active = 1'b0;
      rx_busy  = 1'b0;
    end else if (idle && uart_en) begin
      m_active = 1'b1;
      m_el     = 1;
      m_data   = uart_din;
    end else if (m_active) begin
      m_el++;
      if (m_el > FRAME + 1) m_active = 1'b0;
    end
    fv = {1'b1, m_data, 1'b0};
    exp_txd  = 1'b1;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (m_active && m_el <= FRAME) begin
      exp_txd  = fv[(m_el - 1) / BPS];
      exp_busy = 1'b1;
    end else if (m_active && m_el == FRAME + 1) begin
      exp_done = 1'b1;
      exp_done_cnt++;
      sent_q.push_back(m_data);
    end
  endtask

  task automatic rx_sample();
    int k;
    if (!rx_busy) begin
      if (uart_txd === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= BPS + BPS / 2 && (rx_cnt % BPS) == BPS / 2) begin
        k = rx_cnt / BPS;
        if (k <= 8) begin
          rx_byte[k-1] = uart_txd;
        end else begin
          chk("rx_stop_bit", {31'd0, uart_txd}, 32'd1);
          rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("txd",  {31'd0, uart_txd},     {31'd0, exp_txd});
    chk("busy", {31'd0, uart_tx_busy}, {31'd0, exp_busy});
    chk("done", {31'd0, uart_tx_done}, {31'd0, exp_done});
    if (uart_tx_done === 1'b1) dut_done_cnt++;
    rx_sample();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    uart_din = b;
    uart_en  = 1'b1;
    step();
    uart_en  = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (uart_tx_done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk("wait_done_timeout", {31'd0, uart_tx_done}, 32'd1);
  endtask

  // Random uart_en/uart_din activity that must not disturb the frame in flight.
  task automatic run_noise(input int n);
    for (int i = 0; i < n; i++) begin
      uart_en  = 1'($urandom_range(0, 1));
      uart_din = 8'($urandom);
      step();
    end
    uart_en = 1'b0;
  endtask

  initial begin
    // Reset with a coincident request, which must be ignored.
    rst_n = 1'b1;
    uart_en = 1'b1;
    uart_din = 8'hC7;
    #1;
    run(3);
    rst_n = 1'b0;
    uart_en = 1'b0;
    run(5);

    // 0x55: alternating line levels, done 400 clocks after acceptance.
    send(8'h55);
    wait_done(FRAME + 10);

    // 0x00 then 0xFF with the second request on the done cycle.
    run(3);
    send(8'h00);
    wait_done(FRAME + 10);
    send(8'hFF);
    wait_done(FRAME + 10);
    run(2);

    // A request mid-frame is dropped and the frame in flight is intact.
    send(8'h3C);
    run(98);
    uart_din = 8'hA3;
    uart_en  = 1'b1;
    step();
    uart_en  = 1'b0;
    chk("busy_during_ignored_req", {31'd0, uart_tx_busy}, 32'd1);
    wait_done(FRAME + 10);
    run(2);

    // Reset during data bit 4 aborts the frame, then 0x81 is sent cleanly.
    send(8'h6B);
    run(5 * BPS + 10);
    rst_n   = 1'b1;
    uart_en = 1'b1;
    step();
    rst_n   = 1'b0;
    uart_en = 1'b0;
    chk("txd_after_abort",  {31'd0, uart_txd},     32'd1);
    chk("busy_after_abort", {31'd0, uart_tx_busy}, 32'd0);
    run(FRAME + 5);
    send(8'h81);
    wait_done(FRAME + 10);

    // Randomized bytes with noise on the inputs and random idle gaps.
    for (int f = 0; f < 24; f++) begin
      send(8'($urandom));
      run_noise($urandom_range(0, FRAME - 20));
      wait_done(FRAME + 10);
      run($urandom_range(0, 3));
    end
    run(BPS);

    chk("done_count", dut_done_cnt, exp_done_cnt);
    chk("rx_count", rx_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
      chk("rx_byte", {24'd0, rx_q[i]}, {24'd0, sent_q[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_send.md
UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 2_500_000, line baud rate in bit/s.
REQ-003 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-high (asserted = 1), sampled on rising clk.
REQ-005 uart_en  input  1  transmit request, one-cycle pulse or level; sampled only in IDLE.
REQ-006 uart_din  input  8  byte to transmit; sampled in the cycle uart_en is accepted.
REQ-007 uart_txd  output  1  serial line; idle high.
REQ-008 uart_tx_busy  output  1  high from acceptance through end of stop bit.
REQ-009 uart_tx_done  output  1  one-cycle pulse on frame completion.

Function
REQ-010 Frame SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 Bit period SHALL be BPS_CNT = CLK_FREQ/UART_BPS clocks, integer division (40 at defaults).
REQ-012 FSM states: IDLE, START, DATA, STOP.
REQ-013 IDLE: uart_txd=1, busy=0; uart_en=1 -> latch uart_din into shift register, go START next cycle.
REQ-014 START: uart_txd=0 for exactly BPS_CNT clocks, then DATA.
REQ-015 DATA: uart_txd = latched bit k, k=0..7, each for BPS_CNT clocks; 3-bit bit counter; after bit 7 -> STOP.
REQ-016 STOP: uart_txd=1 for BPS_CNT clocks, then IDLE.
REQ-017 Latency: uart_txd falls in the first cycle after the cycle uart_en is accepted; full frame = 10*BPS_CNT clocks.
REQ-018 uart_tx_done SHALL pulse high for one cycle in the cycle FSM returns to IDLE; never otherwise.
REQ-019 uart_tx_busy SHALL be 1 in START, DATA, STOP; 0 in IDLE.
REQ-020 uart_en while busy SHALL be ignored (not queued); uart_din changes while busy SHALL not affect the frame in flight.
REQ-021 uart_en in the same cycle as uart_tx_done (FSM in IDLE) SHALL be accepted; back-to-back frames have no idle gap beyond that cycle.
REQ-022 Baud counter SHALL count 0..BPS_CNT-1 and wrap, reset to 0 on every state entry; no drift across frames.
REQ-023 uart_txd SHALL be driven directly from a register (glitch-free).

Reset
REQ-024 rst_n=1 on a clock edge SHALL force IDLE, uart_txd=1, uart_tx_busy=0, uart_tx_done=0, counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame: uart_txd high on the next cycle, no done pulse emitted.
REQ-026 uart_en coincident with reset SHALL be ignored.

Structure
REQ-027 Shared package uart_pkg SHALL hold CLK_FREQ/UART_BPS defaults, BPS_CNT derivation and the state encoding, shared with the receiver.
REQ-028 One sub-module, uart_baud_gen (bit-period counter with clear input and end-of-bit tick), SHALL be instantiated; everything else stays in uart_send.

Verification
REQ-029 Send 0x55 at defaults -> uart_txd sequence 0,1,0,1,0,1,0,1,0,1, each level exactly 40 clocks; done pulse at clock 400 after acceptance.
REQ-030 Send 0x00 then 0xFF back-to-back (uart_en asserted on the done cycle) -> two contiguous frames, 800 clocks total, two done pulses.
REQ-031 Pulse uart_en with 0xA3 at clock 100 of a frame carrying 0x3C -> 0xA3 never transmitted, 0x3C frame intact, busy stays 1.
REQ-032 Assert rst_n=1 during data bit 4 -> uart_txd=1, busy=0 next cycle, no done pulse; subsequent 0x81 sends correctly.
REQ-033 Loopback uart_send -> uart_recv, 256 bytes 0x00..0xFF -> every received byte equals sent byte, one receive-done per send-done.
